// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receive and transmit paths.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 2604;
    localparam int DATA_BITS        = 8;
    localparam int CNT_W            = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte side of the UART receiver: data, strobes and busy status.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx_data, rx_valid, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/baud_rate_generator_rx.sv
// Restartable bit-period counter; flags the start-bit mid-point and each full bit period.
module baud_rate_generator_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == LAST_CNT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign half_tick = (cnt_q == HALF_CNT);
    assign full_tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, framing-error detection.
//   state | meaning
//   IDLE  | line high, waiting for a start edge
//   START | timing to start-bit mid-point, rejects glitches
//   DATA  | sampling data bits LSB first
//   STOP  | waiting for stop-bit mid-point
//   BREAK | stop bit was low, waiting for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int IDX_W = $clog2(DATA_BITS);

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 err_q;
    logic                 restart;
    logic                 half_tick;
    logic                 full_tick;
    logic                 shift_en;
    logic                 load_en;
    logic                 err_en;
    logic                 idx_clr;

    assign rx_s = sync_q[1];

    baud_rate_generator_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            if (idx_clr) begin
                idx_q <= '0;
            end else if (shift_en) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            end
            if (load_en) begin
                data_q <= shift_q;
            end
            valid_q <= load_en;
            err_q   <= err_en;
        end
    end

    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        err_en   = 1'b0;
        idx_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                restart = 1'b1;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (half_tick) begin
                    restart = 1'b1;
                    if (!rx_s) begin
                        idx_clr = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        load_en = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_en  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                restart = 1'b1;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes/framing errors, plus latency at default rate.
module tb_uart_rx;

    localparam int C  = 16;
    localparam int C2 = 2604;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ev_t        exp_q[$];
    int         vcyc_q[$];
    logic [7:0] good_model = 8'h00;

    int         v2_cnt = 0;
    int         e2_cnt = 0;
    int         v2_cyc = 0;
    logic [7:0] v2_data = 8'h00;

    uart_rx_if bus1 ();
    uart_rx_if bus2 ();

    uart_rx #(.CLKS_PER_BIT(C)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx1),
        .bus   (bus1)
    );

    uart_rx dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx2),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the fast instance: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus1.rx_valid && bus1.frame_err) chk("valid_and_err", 1, 0);
            if (bus1.rx_valid || bus1.frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {bus1.rx_valid, bus1.frame_err}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", bus1.frame_err, e.err);
                    chk("strobe_data", bus1.rx_data, e.data);
                end
                if (bus1.rx_valid) vcyc_q.push_back(cyc);
            end
            if (bus2.rx_valid) begin
                v2_cnt++;
                v2_cyc  = cyc;
                v2_data = bus2.rx_data;
            end
            if (bus2.frame_err) e2_cnt++;
        end
    end

    task automatic send1(input logic [7:0] d, input bit stop_ok);
        ev_t e;
        e.err  = !stop_ok;
        e.data = stop_ok ? d : good_model;
        exp_q.push_back(e);
        if (stop_ok) good_model = d;
        rx1 = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx1 = d[i];
            repeat (C) @(negedge clk);
        end
        rx1 = stop_ok;
        repeat (C) @(negedge clk);
    endtask

    initial begin
        int n;
        int t_fall;
        logic [7:0] d2;

        repeat (3) @(negedge clk);
        chk("rst_data", bus1.rx_data, 0);
        chk("rst_valid", bus1.rx_valid, 0);
        chk("rst_err", bus1.frame_err, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_busy2", bus2.busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame
        send1(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        chk("a5_busy_after", bus1.busy, 0);
        chk("a5_drained", exp_q.size(), 0);
        chk("a5_data_held", bus1.rx_data, 8'hA5);

        // Short glitch must be rejected, then a clean frame
        rx1 = 1'b0;
        repeat (4) @(negedge clk);
        rx1 = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_idle", bus1.busy, 0);
        chk("glitch_data", bus1.rx_data, 8'hA5);
        send1(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        chk("3c_drained", exp_q.size(), 0);

        // Framing error followed by a held-low line
        send1(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        chk("break_busy", bus1.busy, 1);
        chk("break_drained", exp_q.size(), 0);
        chk("break_data_kept", bus1.rx_data, 8'h3C);
        rx1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_release_idle", bus1.busy, 0);
        repeat (20) @(negedge clk);

        // Back-to-back frames at full line rate
        n = vcyc_q.size();
        send1(8'h00, 1'b1);
        send1(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_count", vcyc_q.size() - n, 2);
        if (vcyc_q.size() - n == 2) chk("b2b_spacing", vcyc_q[n+1] - vcyc_q[n], 10 * C);

        // Reset in the middle of data bit 3 of an abandoned frame
        rx1 = 1'b0;
        repeat (C) @(negedge clk);
        rx1 = 1'b1;
        repeat (3 * C + C / 2) @(negedge clk);
        chk("abort_busy_pre", bus1.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        good_model = 8'h00;
        chk("abort_rst_data", bus1.rx_data, 0);
        chk("abort_rst_valid", bus1.rx_valid, 0);
        chk("abort_rst_err", bus1.frame_err, 0);
        chk("abort_rst_busy", bus1.busy, 0);
        repeat (6 * C) @(negedge clk);
        chk("abort_no_restart", bus1.busy, 0);
        send1(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        chk("81_drained", exp_q.size(), 0);
        chk("81_data", bus1.rx_data, 8'h81);

        // Default rate: latency from the first edge that sees the falling line
        d2 = 8'hC3;
        t_fall = cyc;
        rx2 = 1'b0;
        repeat (C2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx2 = d2[i];
            repeat (C2) @(negedge clk);
        end
        rx2 = 1'b1;
        repeat (C2) @(negedge clk);
        chk("slow_count", v2_cnt, 1);
        chk("slow_data", v2_data, 8'hC3);
        chk("slow_latency", v2_cyc - (t_fall + 1), 2 + C2 / 2 + 9 * C2);
        chk("slow_no_err", e2_cnt, 0);
        chk("slow_busy_after", bus2.busy, 0);

        chk("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
